// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 8-bit serial PRBS with taps 7^5^4^3.
// Optional macro PRBS_CHK_AUTO_RELOCK_EN: drop lock after LOSS_THR errors inside a WINDOW-bit window.
module prbs_checker #(
    parameter int LOCK_CNT = 16,
    parameter int WINDOW   = 64,
    parameter int LOSS_THR = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [31:0]      bit_cnt
);

    if (LOCK_CNT < 2 || LOCK_CNT > 255 || WINDOW < 2 || WINDOW > 256 ||
        LOSS_THR < 1 || LOSS_THR > WINDOW) begin : g_bad_cfg
        $error("prbs_checker: parameter out of range");
    end

    typedef enum logic [1:0] {ST_FILL, ST_VERIFY, ST_LOCKED} state_t;

    state_t     state, state_nxt;
    logic [7:0] s, s_nxt;
    logic [2:0] fill_cnt, fill_nxt;
    logic [7:0] match_cnt, match_nxt;
    logic       pred, mis;
    logic       cnt_bit, cnt_err;

    assign pred = s[7] ^ s[5] ^ s[4] ^ s[3];
    assign mis  = din ^ pred;

`ifdef PRBS_CHK_AUTO_RELOCK_EN
    localparam int WCW = $clog2(WINDOW + 1);
    logic [WCW-1:0] win_cnt, win_cnt_nxt;
    logic [WCW-1:0] win_err, win_err_nxt, win_err_sum;

    assign win_err_sum = win_err + WCW'(mis);
`endif

    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        fill_nxt  = fill_cnt;
        match_nxt = match_cnt;
        cnt_bit   = 1'b0;
        cnt_err   = 1'b0;
`ifdef PRBS_CHK_AUTO_RELOCK_EN
        win_cnt_nxt = win_cnt;
        win_err_nxt = win_err;
`endif
        if (din_valid) begin
            case (state)
                ST_FILL: begin
                    s_nxt = {s[6:0], din};
                    if (fill_cnt == 3'd7) begin
                        fill_nxt  = 3'd0;
                        match_nxt = 8'd0;
                        // An all-zero register would predict zeros forever; refill instead.
                        if (s_nxt != 8'h00)
                            state_nxt = ST_VERIFY;
                    end else begin
                        fill_nxt = fill_cnt + 3'd1;
                    end
                end
                ST_VERIFY: begin
                    s_nxt = {s[6:0], din};
                    if (mis) begin
                        match_nxt = 8'd0;
                        fill_nxt  = 3'd0;
                        state_nxt = ST_FILL;
                    end else if (match_cnt == 8'(LOCK_CNT - 1)) begin
                        match_nxt = 8'd0;
                        state_nxt = ST_LOCKED;
`ifdef PRBS_CHK_AUTO_RELOCK_EN
                        win_cnt_nxt = '0;
                        win_err_nxt = '0;
`endif
                    end else begin
                        match_nxt = match_cnt + 8'd1;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: shift in the prediction so line errors never poison it.
                    s_nxt   = {s[6:0], pred};
                    cnt_bit = 1'b1;
                    cnt_err = mis;
`ifdef PRBS_CHK_AUTO_RELOCK_EN
                    if (win_err_sum == WCW'(LOSS_THR)) begin
                        state_nxt   = ST_FILL;
                        fill_nxt    = 3'd0;
                        win_cnt_nxt = '0;
                        win_err_nxt = '0;
                    end else if (win_cnt == WCW'(WINDOW - 1)) begin
                        win_cnt_nxt = '0;
                        win_err_nxt = '0;
                    end else begin
                        win_cnt_nxt = win_cnt + WCW'(1);
                        win_err_nxt = win_err_sum;
                    end
`endif
                end
                default: state_nxt = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FILL;
            s         <= 8'h00;
            fill_cnt  <= 3'd0;
            match_cnt <= 8'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            bit_cnt   <= '0;
`ifdef PRBS_CHK_AUTO_RELOCK_EN
            win_cnt   <= '0;
            win_err   <= '0;
`endif
        end else begin
            state     <= state_nxt;
            s         <= s_nxt;
            fill_cnt  <= fill_nxt;
            match_cnt <= match_nxt;
            locked    <= (state_nxt == ST_LOCKED);
            err_pulse <= cnt_err;
`ifdef PRBS_CHK_AUTO_RELOCK_EN
            win_cnt   <= win_cnt_nxt;
            win_err   <= win_err_nxt;
`endif
            // clr takes priority over a coincident count event.
            if (clr) begin
                err_cnt <= '0;
                bit_cnt <= '0;
            end else begin
                if (cnt_err && !(&err_cnt))
                    err_cnt <= err_cnt + 1'b1;
                if (cnt_bit && !(&bit_cnt))
                    bit_cnt <= bit_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised scoreboard bench for prbs_checker against a queue-based behavioural model.
// Honours PRBS_CHK_AUTO_RELOCK_EN the same way the design does.
module tb_prbs_checker;
    localparam int LOCK_CNT = 16;
    localparam int WINDOW   = 64;
    localparam int LOSS_THR = 4;
    localparam int ERR_W    = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             din = 1'b0;
    logic             din_valid = 1'b0;
    logic             clr = 1'b0;
    logic             locked, err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic [31:0]      bit_cnt;

    prbs_checker #(.LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW), .LOSS_THR(LOSS_THR), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stamp;
        logic        lk;
        logic        ep;
        logic [31:0] ec;
        logic [31:0] bc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_mis = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a sliding history of the last 8 context bits plus plain counters.
    localparam int M_FILL = 0, M_VERIFY = 1, M_LOCK = 2;
    bit     hist[$];
    int     mode, nfill, nmatch, wcnt, werr;
    longint errs, bits;
    bit     pulse_m;
    logic [7:0] gen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s @cycle %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    task automatic model_step(input bit d, input bit v, input bit c, input bit r);
        bit p, e_err, any;
        e_err = 1'b0;
        if (r) begin
            hist.delete();
            repeat (8) hist.push_back(1'b0);
            mode = M_FILL; nfill = 0; nmatch = 0; wcnt = 0; werr = 0;
            errs = 0; bits = 0;
        end else begin
            if (v) begin
                // hist[0] is the bit 8 positions back: a[m] = a[m-8]^a[m-6]^a[m-5]^a[m-4]
                p = hist[0] ^ hist[2] ^ hist[3] ^ hist[4];
                case (mode)
                    M_FILL: begin
                        hist.push_back(d); void'(hist.pop_front());
                        nfill++;
                        if (nfill == 8) begin
                            nfill = 0;
                            any = 1'b0;
                            foreach (hist[i]) any |= hist[i];
                            if (any) begin mode = M_VERIFY; nmatch = 0; end
                        end
                    end
                    M_VERIFY: begin
                        hist.push_back(d); void'(hist.pop_front());
                        if (d != p) begin
                            mode = M_FILL; nfill = 0;
                        end else begin
                            nmatch++;
                            if (nmatch == LOCK_CNT) begin mode = M_LOCK; wcnt = 0; werr = 0; end
                        end
                    end
                    default: begin
                        hist.push_back(p); void'(hist.pop_front());
                        if (!c && bits < 64'hFFFF_FFFF) bits++;
                        wcnt++;
                        if (d != p) begin
                            e_err = 1'b1;
                            werr++;
                            if (!c && errs < (64'd1 << ERR_W) - 1) errs++;
                        end
`ifdef PRBS_CHK_AUTO_RELOCK_EN
                        if (werr >= LOSS_THR) begin
                            mode = M_FILL; nfill = 0;
                        end else if (wcnt == WINDOW) begin
                            wcnt = 0; werr = 0;
                        end
`endif
                    end
                endcase
            end
            if (c) begin errs = 0; bits = 0; end
        end
        pulse_m = e_err;
    endtask

    task automatic step(input bit d, input bit v, input bit c, input bit r);
        exp_t e;
        @(negedge clk);
        din = d; din_valid = v; clr = c; rst = r;
        model_step(d, v, c, r);
        e.stamp = cyc;
        e.lk    = (mode == M_LOCK);
        e.ep    = pulse_m;
        e.ec    = 32'(errs);
        e.bc    = 32'(bits);
        sb.push_back(e);
    endtask

    task automatic next_gen(output bit b);
        b   = gen[7];
        gen = {gen[6:0], gen[7] ^ gen[5] ^ gen[4] ^ gen[3]};
    endtask

    task automatic good(input int n);
        bit b;
        for (int i = 0; i < n; i++) begin next_gen(b); step(b, 1'b1, 1'b0, 1'b0); end
    endtask

    task automatic flip(input bit c);
        bit b;
        next_gen(b);
        step(~b, 1'b1, c, 1'b0);
    endtask

    task automatic do_reset(input logic [7:0] seed);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        gen = seed;
    endtask

    // Monitor: outputs are registered, so every clocked cycle presents a result.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].stamp < cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("locked",    32'(locked),    32'(e.lk));
            chk("err_pulse", 32'(err_pulse), 32'(e.ep));
            chk("err_cnt",   32'(err_cnt),   e.ec);
            chk("bit_cnt",   bit_cnt,        e.bc);
        end
    end

    initial begin
        bit b;
        // Lock-up from seed A5, then continuous good data.
        do_reset(8'hA5);
        good(64);
        // Single error while locked, then flywheel through 100 clean bits.
        flip(1'b0);
        good(100);
        // Four errors in one window.
        flip(1'b0); good(3); flip(1'b0); good(5); flip(1'b0); good(2); flip(1'b0);
        good(60);
        // Constant zero stream never leaves FILL.
        do_reset(8'hA5);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        // 50% valid during lock-up; invalid cycles carry random din.
        do_reset(8'hA5);
        for (int n = 0; n < 40; ) begin
            if ($urandom_range(0, 1) != 0) begin
                next_gen(b); step(b, 1'b1, 1'b0, 1'b0); n++;
            end else begin
                step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
            end
        end
        // clr coincident with an injected error.
        good(5);
        flip(1'b1);
        good(10);
        // Random valid / error / clr mix from a random seed.
        do_reset(8'($urandom_range(1, 255)));
        for (int i = 0; i < 3000; i++) begin
            bit v, er, c;
            v  = ($urandom_range(0, 3) != 0);
            er = ($urandom_range(0, 39) == 0);
            c  = ($urandom_range(0, 99) == 0);
            if (v) begin next_gen(b); step(b ^ er, 1'b1, c, 1'b0); end
            else step(1'($urandom_range(0, 1)), 1'b0, c, 1'b0);
        end
        // Saturate err_cnt: one error every 22 bits keeps at most 3 per window.
        do_reset(8'h5A);
        good(30);
        for (int i = 0; i < 6000; i++) begin
            if (i % 22 == 0) flip(1'b0); else good(1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("err_cnt_saturated", 32'(err_cnt), 32'hFF);
        chk("locked_during_sat", 32'(locked), 32'd1);
        // Reset mid-lock.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        good(30);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
